// File: rtl/ps2_dir_queue_pkg.sv
// ============================================================================
// ps2_dir_queue_pkg : shared encodings for the PS/2 direction queue
// Rev 1.0
// ============================================================================
`default_nettype none

package ps2_dir_queue_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

    // Up/down and left/right differ only in the LSB of their encoding.
    function automatic dir_e dir_opposite(input dir_e d);
        return dir_e'(d ^ 2'b01);
    endfunction

    // Held vector is ordered {up,down,left,right}.
    function automatic logic [3:0] dir_held_mask(input dir_e d);
        return 4'b1000 >> d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_dir_queue_if.sv
// ============================================================================
// ps2_dir_queue_if : scan-code input, queue consumer and status signals
// Rev 1.0
// ============================================================================
`default_nettype none

interface ps2_dir_queue_if;
    import ps2_dir_queue_pkg::*;

    logic       ps2_done;
    logic [7:0] ps2_data;
    logic       pop;
    logic       dir_valid;
    dir_e       dir_code;
    logic [3:0] held;
    logic       pause_toggle;
    logic       overflow;

    modport master (
        output ps2_done, ps2_data, pop,
        input  dir_valid, dir_code, held, pause_toggle, overflow
    );

    modport slave (
        input  ps2_done, ps2_data, pop,
        output dir_valid, dir_code, held, pause_toggle, overflow
    );

endinterface

`default_nettype wire

// File: rtl/ps2_dir_queue_sync_fifo.sv
// ============================================================================
// ps2_dir_queue_sync_fifo : single-clock FIFO, power-of-two depth
// Rev 1.0
// ============================================================================
`default_nettype none

module ps2_dir_queue_sync_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         din,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         dout,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_dir_queue.sv
// ============================================================================
// ps2_dir_queue : PS/2 set-2 arrow/space decoder feeding a direction queue
// Rev 1.0
// ============================================================================
`default_nettype none

module ps2_dir_queue
    import ps2_dir_queue_pkg::*;
#(
    parameter int FIFO_DEPTH       = 4,
    parameter int BLOCK_REVERSE    = 1,
    parameter int TYPEMATIC_FILTER = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    ps2_dir_queue_if.slave  bus
);

    localparam int AW = $clog2(FIFO_DEPTH);

    dec_state_e state_q, state_d;
    logic [3:0] held_q, held_d;
    logic       space_held_q, space_held_d;
    dir_e       last_dir_q, last_dir_d;
    logic       last_vld_q, last_vld_d;
    logic       pause_q, pause_d;
    logic       ovf_q, ovf_d;

    logic       byte_decoded;
    logic       is_break;
    logic       key_is_dir;
    logic       key_is_space;
    dir_e       key_dir;
    logic [3:0] dir_mask;
    logic       dir_make;
    logic       dir_break;
    logic       dir_repeat;
    logic       dir_redundant;
    logic       push_req;
    logic       pop_ok;
    logic       dir_valid;

    logic [1:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic [AW:0] fifo_count;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: only prefix bytes move away from IDLE
    always_comb begin
        state_d = state_q;
        if (bus.ps2_done) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.ps2_data == SC_EXT)      state_d = ST_EXT;
                    else if (bus.ps2_data == SC_BRK) state_d = ST_BRK;
                    else                             state_d = ST_IDLE;
                end
                ST_EXT:  state_d = (bus.ps2_data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic: which strobes carry a key code, and of what kind
    always_comb begin
        byte_decoded = bus.ps2_done
                     && !((state_q == ST_IDLE) && (bus.ps2_data == SC_EXT || bus.ps2_data == SC_BRK))
                     && !((state_q == ST_EXT)  && (bus.ps2_data == SC_BRK));
        is_break     = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        key_is_dir   = 1'b1;
        key_is_space = 1'b0;
        key_dir      = DIR_UP;
        case (bus.ps2_data)
            SC_UP:    key_dir = DIR_UP;
            SC_DOWN:  key_dir = DIR_DOWN;
            SC_LEFT:  key_dir = DIR_LEFT;
            SC_RIGHT: key_dir = DIR_RIGHT;
            SC_SPACE: begin
                key_is_dir   = 1'b0;
                key_is_space = 1'b1;
            end
            default:  key_is_dir = 1'b0;
        endcase
    end

    always_comb begin
        dir_mask      = dir_held_mask(key_dir);
        dir_make      = byte_decoded && !is_break && key_is_dir;
        dir_break     = byte_decoded &&  is_break && key_is_dir;
        dir_repeat    = (TYPEMATIC_FILTER != 0) && ((held_q & dir_mask) != 4'b0000);
        dir_redundant = last_vld_q && ((key_dir == last_dir_q)
                        || ((BLOCK_REVERSE != 0) && (key_dir == dir_opposite(last_dir_q))));
        push_req      = dir_make && !dir_repeat && !dir_redundant;
        pop_ok        = bus.pop && !fifo_empty;

        held_d = held_q;
        if (dir_make)  held_d = held_q |  dir_mask;
        if (dir_break) held_d = held_q & ~dir_mask;

        space_held_d = space_held_q;
        pause_d      = 1'b0;
        if (byte_decoded && key_is_space) begin
            if (is_break) begin
                space_held_d = 1'b0;
            end else begin
                space_held_d = 1'b1;
                pause_d      = !((TYPEMATIC_FILTER != 0) && space_held_q);
            end
        end

        // last_dir only follows entries that actually landed in the queue
        last_dir_d = last_dir_q;
        last_vld_d = last_vld_q;
        ovf_d      = 1'b0;
        if (push_req) begin
            if (!fifo_full || pop_ok) begin
                last_dir_d = key_dir;
                last_vld_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_q       <= 4'b0000;
            space_held_q <= 1'b0;
            last_dir_q   <= DIR_UP;
            last_vld_q   <= 1'b0;
            pause_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            held_q       <= held_d;
            space_held_q <= space_held_d;
            last_dir_q   <= last_dir_d;
            last_vld_q   <= last_vld_d;
            pause_q      <= pause_d;
            ovf_q        <= ovf_d;
        end
    end

    ps2_dir_queue_sync_fifo #(
        .WIDTH (2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .din   (key_dir),
        .pop   (bus.pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign dir_valid        = (fifo_count != '0);
    assign bus.dir_valid    = dir_valid;
    assign bus.dir_code     = dir_valid ? dir_e'(fifo_dout) : DIR_UP;
    assign bus.held         = held_q;
    assign bus.pause_toggle = pause_q;
    assign bus.overflow     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_dir_queue.sv
// ============================================================================
// tb_ps2_dir_queue : directed + random bench for two parameterisations
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ps2_dir_queue;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_dir_queue_if bus_a ();
    ps2_dir_queue_if bus_b ();

    ps2_dir_queue #(.FIFO_DEPTH(4), .BLOCK_REVERSE(1), .TYPEMATIC_FILTER(1)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a));
    ps2_dir_queue #(.FIFO_DEPTH(4), .BLOCK_REVERSE(0), .TYPEMATIC_FILTER(0)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b));

    int checks = 0;
    int errors = 0;

    // Reference model, index 0 = dut_a (filters on), 1 = dut_b (filters off)
    bit       m_ext   [2];
    bit       m_brk   [2];
    bit [3:0] m_held  [2];
    bit       m_space [2];
    int       m_last  [2];
    int       m_q     [2][4];
    int       m_n     [2];
    bit       m_pause [2];
    bit       m_ovf   [2];

    logic [1:0] exp_pop4 [4];
    logic [7:0] rnd_tab  [8];
    logic [7:0] fill_seq [5];
    logic [7:0] rb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int key_dir(input logic [7:0] b);
        case (b)
            8'h75:   return 0;
            8'h72:   return 1;
            8'h6B:   return 2;
            8'h74:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ext[k] = 0; m_brk[k] = 0; m_held[k] = 4'b0000; m_space[k] = 0;
            m_last[k] = -1; m_n[k] = 0; m_pause[k] = 0; m_ovf[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit done, input logic [7:0] b, input bit pop);
        bit filt, pop_ok, full_before, push, brk;
        int d, pd;
        filt = (k == 0);
        m_pause[k] = 0; m_ovf[k] = 0; push = 0; pd = 0;
        full_before = (m_n[k] == 4);
        pop_ok      = pop && (m_n[k] > 0);
        if (done) begin
            if (!m_ext[k] && !m_brk[k] && b == 8'hE0) m_ext[k] = 1;
            else if (!m_brk[k] && b == 8'hF0)         m_brk[k] = 1;
            else begin
                brk = m_brk[k]; m_ext[k] = 0; m_brk[k] = 0;
                d = key_dir(b);
                if (d >= 0) begin
                    if (brk) m_held[k][3-d] = 0;
                    else if (!(filt && m_held[k][3-d])) begin
                        m_held[k][3-d] = 1;
                        if (m_last[k] < 0 || (d != m_last[k] && !(filt && d == (m_last[k] ^ 1)))) begin
                            push = 1; pd = d;
                        end
                    end
                end else if (b == 8'h29) begin
                    if (brk) m_space[k] = 0;
                    else if (!(filt && m_space[k])) begin
                        m_space[k] = 1; m_pause[k] = 1;
                    end
                end
            end
        end
        if (pop_ok) begin
            for (int i = 0; i < 3; i++) m_q[k][i] = m_q[k][i+1];
            m_n[k]--;
        end
        if (push) begin
            if (!full_before || pop_ok) begin
                m_q[k][m_n[k]] = pd; m_n[k]++; m_last[k] = pd;
            end else begin
                m_ovf[k] = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("a.valid", bus_a.dir_valid, m_n[0] != 0);
        if (m_n[0] != 0) chk("a.code", bus_a.dir_code, m_q[0][0]);
        chk("a.held",  bus_a.held,         m_held[0]);
        chk("a.pause", bus_a.pause_toggle, m_pause[0]);
        chk("a.ovf",   bus_a.overflow,     m_ovf[0]);
        chk("b.valid", bus_b.dir_valid, m_n[1] != 0);
        if (m_n[1] != 0) chk("b.code", bus_b.dir_code, m_q[1][0]);
        chk("b.held",  bus_b.held,         m_held[1]);
        chk("b.pause", bus_b.pause_toggle, m_pause[1]);
        chk("b.ovf",   bus_b.overflow,     m_ovf[1]);
    endtask

    task automatic step(input bit done, input logic [7:0] b, input bit pop);
        bus_a.ps2_done = done; bus_a.ps2_data = b; bus_a.pop = pop;
        bus_b.ps2_done = done; bus_b.ps2_data = b; bus_b.pop = pop;
        model_step(0, done, b, pop);
        model_step(1, done, b, pop);
        @(posedge clk);
        #1;
        bus_a.ps2_done = 0; bus_a.pop = 0;
        bus_b.ps2_done = 0; bus_b.pop = 0;
        check_all();
    endtask

    task automatic make_key(input logic [7:0] code);
        step(1, 8'hE0, 0);
        step(1, code, 0);
    endtask

    task automatic break_key(input logic [7:0] code);
        step(1, 8'hE0, 0);
        step(1, 8'hF0, 0);
        step(1, code, 0);
    endtask

    // Reset is asserted between edges so its effect is seen without a clock
    task automatic do_reset();
        bus_a.ps2_done = 0; bus_a.pop = 0; bus_b.ps2_done = 0; bus_b.pop = 0;
        #2 rst = 1'b0;
        #1;
        chk("rst.a.valid", bus_a.dir_valid, 1'b0);
        chk("rst.a.code",  bus_a.dir_code,  2'b00);
        chk("rst.a.held",  bus_a.held,      4'b0000);
        chk("rst.a.pause", bus_a.pause_toggle, 1'b0);
        chk("rst.a.ovf",   bus_a.overflow,  1'b0);
        chk("rst.b.valid", bus_b.dir_valid, 1'b0);
        chk("rst.b.held",  bus_b.held,      4'b0000);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        exp_pop4 = '{2'b10, 2'b00, 2'b11, 2'b01};
        rnd_tab  = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'hE0};
        fill_seq = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6B};
        bus_a.ps2_done = 0; bus_a.ps2_data = 8'h00; bus_a.pop = 0;
        bus_b.ps2_done = 0; bus_b.ps2_data = 8'h00; bus_b.pop = 0;
        model_reset();

        // First make of up is visible the cycle after its last byte
        do_reset();
        make_key(8'h75);
        chk("r031.valid", bus_a.dir_valid, 1'b1);
        chk("r031.code",  bus_a.dir_code,  2'b00);
        chk("r031.held",  bus_a.held,      4'b1000);

        // Opposite direction: dropped with reverse blocking, queued without
        make_key(8'h72);
        step(0, 8'h00, 1);
        chk("r032.a_empty", bus_a.dir_valid, 1'b0);
        chk("r032.b_valid", bus_b.dir_valid, 1'b1);
        chk("r032.b_code",  bus_b.dir_code,  2'b01);
        step(0, 8'h00, 1);

        // Five directions into a four-deep queue
        do_reset();
        for (int i = 0; i < 5; i++) begin
            make_key(fill_seq[i]);
            if (i == 4) begin
                chk("r033.ovf_a", bus_a.overflow, 1'b1);
                chk("r033.ovf_b", bus_b.overflow, 1'b1);
            end
            break_key(fill_seq[i]);
        end
        for (int i = 0; i < 4; i++) begin
            chk("r033.pop_code", bus_a.dir_code, exp_pop4[i]);
            step(0, 8'h00, 1);
        end
        chk("r033.drained", bus_a.dir_valid, 1'b0);

        // Refill, then push and pop in the same cycle on a full queue
        for (int i = 0; i < 4; i++) begin
            make_key(fill_seq[i]);
            break_key(fill_seq[i]);
        end
        step(1, 8'hE0, 0);
        step(1, 8'h6B, 1);
        chk("r034.no_ovf", bus_a.overflow, 1'b0);
        chk("r034.head",   bus_a.dir_code, 2'b00);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1);
        chk("r034.drained", bus_a.dir_valid, 1'b0);

        // Typematic repeats and re-press of the same key
        do_reset();
        make_key(8'h6B);  chk("r035.h1", bus_a.held, 4'b0010);
        make_key(8'h6B);  chk("r035.h2", bus_a.held, 4'b0010);
        break_key(8'h6B); chk("r035.h3", bus_a.held, 4'b0000);
        make_key(8'h6B);  chk("r035.h4", bus_a.held, 4'b0010);
        step(0, 8'h00, 1);
        chk("r035.one_entry", bus_a.dir_valid, 1'b0);

        // Reset after a prefix byte discards it
        step(1, 8'hE0, 0);
        do_reset();
        step(1, 8'h29, 0);
        chk("r036.pulse", bus_a.pause_toggle, 1'b1);
        chk("r036.empty", bus_a.dir_valid,    1'b0);
        step(0, 8'h00, 0);
        chk("r036.once",  bus_a.pause_toggle, 1'b0);
        step(1, 8'h29, 0);
        chk("r036.filtered", bus_a.pause_toggle, 1'b0);

        // Random scan-code stream
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                rb = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                  : rnd_tab[$urandom_range(0, 7)];
                step($urandom_range(0, 3) != 0, rb, $urandom_range(0, 4) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ps2_dir_queue.md
PS2_DIR_QUEUE -- requirements
Module: ps2_dir_queue

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: direction-command queue depth; power of two, >= 2.
REQ-002 Parameter BLOCK_REVERSE, default 1: 1 = discard a direction opposite to the last enqueued one.
REQ-003 Parameter TYPEMATIC_FILTER, default 1: 1 = ignore repeated make codes of a key already held.
REQ-004 Port clk  in  1  system clock; all logic on rising edge.
REQ-005 Port rst  in  1  asynchronous, active-low reset.
REQ-006 Port ps2_done  in  1  one-cycle strobe, ps2_data valid.
REQ-007 Port ps2_data  in  8  received scan-code byte (set 2).
REQ-008 Port pop  in  1  consumer takes head entry this cycle.
REQ-009 Port dir_valid  out  1  queue non-empty.
REQ-010 Port dir_code  out  2  head entry: 00 up, 01 down, 10 left, 11 right.
REQ-011 Port held  out  4  level per key {up,down,left,right}, set on make, cleared on break.
REQ-012 Port pause_toggle  out  1  one-cycle pulse on space (0x29) make.
REQ-013 Port overflow  out  1  one-cycle pulse when a direction is dropped because the queue is full.

Function
REQ-014 Decoder FSM states: IDLE, EXT (after 0xE0), BRK (after 0xF0), EXT_BRK (0xE0 then 0xF0); advances only on ps2_done.
REQ-015 Transitions: IDLE -0xE0-> EXT; IDLE -0xF0-> BRK; EXT -0xF0-> EXT_BRK; any other byte in any state is decoded, then returns to IDLE.
REQ-016 Key map, E0 prefix optional: 0x75 up, 0x72 down, 0x6B left, 0x74 right, 0x29 space; other codes ignored, FSM returns to IDLE.
REQ-017 Break (BRK/EXT_BRK) of a mapped direction clears its held bit; nothing enqueued.
REQ-018 Make of a direction sets its held bit; with TYPEMATIC_FILTER=1 and bit already set, event is ignored.
REQ-019 Accepted make enqueued unless: equal to last_dir, or (BLOCK_REVERSE=1) opposite to last_dir (up/down, left/right).
REQ-020 last_dir updates only on successful enqueue; after reset it is "none" and nothing is rejected.
REQ-021 Enqueue is registered: dir_valid/dir_code reflect the entry on the cycle after the final ps2_done byte.
REQ-022 pop with dir_valid=0 is ignored; pop on last entry deasserts dir_valid next cycle.
REQ-023 Full queue with push and no pop: entry dropped, overflow pulses, last_dir unchanged.
REQ-024 Full queue with push and pop same cycle: push accepted, count unchanged, no overflow.
REQ-025 Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
REQ-026 pause_toggle pulses one cycle after space make; held-space repeats suppressed when TYPEMATIC_FILTER=1.

Reset
REQ-027 rst low asynchronously forces: FSM IDLE, queue empty, dir_valid 0, dir_code 00, held 0000, pause_toggle 0, overflow 0, last_dir none.
REQ-028 rst mid-sequence (after E0 or F0) discards the partial code; first post-reset byte decodes from IDLE.

Structure
REQ-029 Shared package holds: direction encodings, scan-code constants (0xE0, 0xF0, 0x75, 0x72, 0x6B, 0x74, 0x29), FSM state typedef.
REQ-030 Queue implemented as one sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count); decoder and filter stay in top.

Verification
REQ-031 Reset, then E0 75 strobes -> dir_valid=1, dir_code=00 one cycle after last strobe, held=1000.
REQ-032 Queue up (E0 75) then down (E0 72), BLOCK_REVERSE=1 -> one entry only; BLOCK_REVERSE=0 -> two entries 00,01.
REQ-033 FIFO_DEPTH=4, enqueue left,up,right,down,left with no pop -> 4 entries, overflow pulses once on 5th; pop x4 returns 10,00,11,01.
REQ-034 Full queue, push and pop same cycle -> count stays 4, no overflow, new entry at tail.
REQ-035 E0 6B, E0 6B, E0 F0 6B, E0 6B -> held bit left toggles 1,1,0,1; with TYPEMATIC_FILTER=1 one enqueue only (second 6B filtered; third make equals last_dir).
REQ-036 E0 then rst pulse then 29 -> pause_toggle pulses once, queue empty, FSM IDLE.
